// File: rtl/trg_frame_packer.sv
// trg_frame_packer: packs 48-bit comparator words into 4-word GTX frames.
// Optional PRBS-7 payload source is enabled by defining TRG_PRBS_EN.
module trg_frame_packer #(
    parameter int unsigned FIFO_DEPTH = 4,
    parameter logic [31:0] IDLE_WORD  = 32'h50BC50BC,
    parameter logic [3:0]  IDLE_ISK   = 4'b0101
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic        TXRESETDONE,
    input  logic [47:0] COMP_DATA,
    input  logic        COMP_VLD,
    output logic        COMP_RDY,
    input  logic        PRBS_SEL,
    output logic [31:0] TX_DATA,
    output logic [3:0]  TX_ISK,
    output logic [7:0]  FRAME_SEQ,
    output logic        LINK_UP
);

    localparam int unsigned AW = $clog2(FIFO_DEPTH);

    typedef enum logic [2:0] {
        LINK_WAIT,
        IDLE,
        W0,
        W1,
        W2,
        W3
    } state_t;

    state_t state, state_n;

    logic [3:0]    link_cnt;
    logic          link_ok;

    logic [47:0]   fifo_mem [FIFO_DEPTH];
    logic [AW:0]   wr_ptr, rd_ptr;
    logic [AW-1:0] rd_idx;
    logic          empty, full;
    logic          push, pop, flush;

    logic          use_prbs;
    logic          src_avail;
    logic          load;
    logic [47:0]   src_payload;

    logic [47:0]   frm_payload;
    logic [7:0]    frm_seq;
    logic [15:0]   frm_crc;
    logic [7:0]    seq_cnt;

    logic [31:0]   tx_data_n;
    logic [3:0]    tx_isk_n;

    // CRC-16-CCITT, init FFFF, MSB first, no reflection, no final xor
    function automatic logic [15:0] crc16(input logic [55:0] msg);
        logic [15:0] c;
        c = 16'hFFFF;
        for (int i = 55; i >= 0; i--) begin
            if (c[15] ^ msg[i])
                c = {c[14:0], 1'b0} ^ 16'h1021;
            else
                c = {c[14:0], 1'b0};
        end
        return c;
    endfunction

    // Link is usable only while qualified and still reporting reset done
    assign link_ok = LINK_UP && TXRESETDONE;
    assign flush   = !link_ok;

    // Qualify TXRESETDONE over 16 consecutive cycles
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            link_cnt <= '0;
            LINK_UP  <= 1'b0;
        end else if (!TXRESETDONE) begin
            link_cnt <= '0;
            LINK_UP  <= 1'b0;
        end else if (link_cnt == 4'hF) begin
            LINK_UP  <= 1'b1;
        end else begin
            link_cnt <= link_cnt + 4'd1;
        end
    end

    assign rd_idx   = rd_ptr[AW-1:0];
    assign empty    = (wr_ptr == rd_ptr);
    assign full     = (wr_ptr[AW] != rd_ptr[AW]) &&
                      (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign COMP_RDY = LINK_UP && !full;
    assign push     = COMP_VLD && COMP_RDY;
    assign pop      = load && !use_prbs;

    // FIFO pointers; a link drop discards everything queued
    always_ff @(posedge CLK) begin
        if (!RST_N || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // FIFO storage, no reset needed
    always_ff @(posedge CLK) begin
        if (push)
            fifo_mem[wr_ptr[AW-1:0]] <= COMP_DATA;
    end

`ifdef TRG_PRBS_EN
    logic [6:0]  prbs_q, prbs_n;
    logic [47:0] prbs_word;

    // Next 48 PRBS-7 bits, first generated bit lands in payload[47]
    always_comb begin
        prbs_n    = prbs_q;
        prbs_word = '0;
        for (int i = 0; i < 48; i++) begin
            prbs_word = {prbs_word[46:0], prbs_n[6] ^ prbs_n[5]};
            prbs_n    = {prbs_n[5:0], prbs_n[6] ^ prbs_n[5]};
        end
    end

    // PRBS state advances only when a PRBS frame is loaded
    always_ff @(posedge CLK) begin
        if (!RST_N)
            prbs_q <= 7'h7F;
        else if (load && use_prbs)
            prbs_q <= prbs_n;
    end

    assign use_prbs    = PRBS_SEL;
    assign src_payload = use_prbs ? prbs_word : fifo_mem[rd_idx];
`else
    logic prbs_sel_unused;
    assign prbs_sel_unused = PRBS_SEL;
    assign use_prbs        = 1'b0;
    assign src_payload     = fifo_mem[rd_idx];
`endif

    assign src_avail = use_prbs || !empty;

    // Frame sequencing and next registered link word
    always_comb begin
        state_n   = state;
        load      = 1'b0;
        tx_data_n = IDLE_WORD;
        tx_isk_n  = IDLE_ISK;
        if (!link_ok) begin
            state_n = LINK_WAIT;
        end else begin
            unique case (state)
                LINK_WAIT: state_n = IDLE;
                IDLE: begin
                    if (src_avail) begin
                        load    = 1'b1;
                        state_n = W0;
                    end
                end
                W0: begin
                    tx_data_n = {frm_payload[47:32], frm_seq, 8'hBC};
                    tx_isk_n  = 4'b0001;
                    state_n   = W1;
                end
                W1: begin
                    tx_data_n = frm_payload[31:0];
                    tx_isk_n  = 4'b0000;
                    state_n   = W2;
                end
                W2: begin
                    tx_data_n = {frm_crc, 16'h0000};
                    tx_isk_n  = 4'b0000;
                    state_n   = W3;
                end
                W3: begin
                    if (src_avail) begin
                        load    = 1'b1;
                        state_n = W0;
                    end else begin
                        state_n = IDLE;
                    end
                end
                default: state_n = LINK_WAIT;
            endcase
        end
    end

    // State and registered GTX outputs
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state   <= LINK_WAIT;
            TX_DATA <= IDLE_WORD;
            TX_ISK  <= IDLE_ISK;
        end else begin
            state   <= state_n;
            TX_DATA <= tx_data_n;
            TX_ISK  <= tx_isk_n;
        end
    end

    // Frame register, CRC and sequence numbering at frame load
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            frm_payload <= '0;
            frm_seq     <= '0;
            frm_crc     <= '0;
            seq_cnt     <= '0;
            FRAME_SEQ   <= '0;
        end else if (load) begin
            frm_payload <= src_payload;
            frm_seq     <= seq_cnt;
            frm_crc     <= crc16({seq_cnt, src_payload});
            seq_cnt     <= seq_cnt + 8'd1;
            FRAME_SEQ   <= seq_cnt;
        end
    end

endmodule

// File: tb/tb_trg_frame_packer.sv
// tb_trg_frame_packer: scoreboard bench for trg_frame_packer.
// Define TRG_PRBS_EN to also exercise the PRBS-7 payload source.
module tb_trg_frame_packer;

    localparam logic [31:0] IDLE_W = 32'h50BC50BC;
    localparam logic [3:0]  IDLE_K = 4'b0101;

    logic        CLK = 1'b0;
    logic        RST_N;
    logic        TXRESETDONE;
    logic [47:0] COMP_DATA;
    logic        COMP_VLD;
    logic        COMP_RDY;
    logic        PRBS_SEL;
    logic [31:0] TX_DATA;
    logic [3:0]  TX_ISK;
    logic [7:0]  FRAME_SEQ;
    logic        LINK_UP;

    trg_frame_packer #(
        .FIFO_DEPTH(4),
        .IDLE_WORD (IDLE_W),
        .IDLE_ISK  (IDLE_K)
    ) dut (
        .CLK        (CLK),
        .RST_N      (RST_N),
        .TXRESETDONE(TXRESETDONE),
        .COMP_DATA  (COMP_DATA),
        .COMP_VLD   (COMP_VLD),
        .COMP_RDY   (COMP_RDY),
        .PRBS_SEL   (PRBS_SEL),
        .TX_DATA    (TX_DATA),
        .TX_ISK     (TX_ISK),
        .FRAME_SEQ  (FRAME_SEQ),
        .LINK_UP    (LINK_UP)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [47:0] p;
        logic [7:0]  s;
        logic [15:0] c;
    } frm_t;

    frm_t     sb[$];
    int       n_chk = 0;
    int       n_fail = 0;
    logic [7:0] exp_seq = 8'd0;
    bit       mon_en = 1'b0;
    int       mon_pos = 0;
    bit       expect_abort = 1'b0;
    bit       abort_seen = 1'b0;

    task automatic check(input string nm, input logic [63:0] act,
                         input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    function automatic logic [15:0] crc_ref(input logic [55:0] m);
        logic [15:0] c;
        c = 16'hFFFF;
        for (int b = 6; b >= 0; b--) begin
            c = c ^ {m[b*8 +: 8], 8'h00};
            for (int k = 0; k < 8; k++)
                c = c[15] ? ({c[14:0], 1'b0} ^ 16'h1021) : {c[14:0], 1'b0};
        end
        return c;
    endfunction

    task automatic expect_frame(input logic [47:0] p);
        frm_t f;
        f.p = p;
        f.s = exp_seq;
        f.c = crc_ref({exp_seq, p});
        sb.push_back(f);
        exp_seq = exp_seq + 8'd1;
    endtask

    // Called on a negedge; returns on the negedge after the accept edge
    task automatic send(input logic [47:0] p, output bit waited);
        int t;
        t = 0;
        waited = 1'b0;
        COMP_DATA = p;
        COMP_VLD = 1'b1;
        while (!COMP_RDY && t < 200) begin
            @(negedge CLK);
            t++;
            waited = 1'b1;
        end
        if (!COMP_RDY) begin
            n_chk++;
            n_fail++;
            $display("FAIL send_timeout: got rdy=0 want rdy=1 p=%h", p);
        end else begin
            expect_frame(p);
        end
        @(negedge CLK);
        COMP_VLD = 1'b0;
    endtask

    task automatic drain();
        int t;
        t = 0;
        while ((sb.size() != 0 || mon_pos != 0) && t < 3000) begin
            @(negedge CLK);
            t++;
        end
        check("drain", 64'(sb.size()), 64'd0);
        repeat (3) @(negedge CLK);
    endtask

    // Monitor: pops expected frames when a W0 appears on the link
    initial begin : monitor
        frm_t cur;
        logic [35:0] exp_w;
        wait (mon_en);
        forever begin
            @(negedge CLK);
            if (mon_pos == 0) begin
                if (TX_ISK == 4'b0001) begin
                    if (sb.size() == 0) begin
                        n_chk++;
                        n_fail++;
                        $display("FAIL unexpected_frame: got %h want none",
                                 TX_DATA);
                    end else begin
                        cur = sb.pop_front();
                        check("w0", {TX_ISK, TX_DATA},
                              {4'b0001, cur.p[47:32], cur.s, 8'hBC});
                        check("frame_seq", 64'(FRAME_SEQ), 64'(cur.s));
                        mon_pos = 1;
                    end
                end else begin
                    check("idle", {TX_ISK, TX_DATA}, {IDLE_K, IDLE_W});
                end
            end else if (expect_abort && mon_pos >= 2 &&
                         TX_DATA == IDLE_W && TX_ISK == IDLE_K) begin
                abort_seen = 1'b1;
                expect_abort = 1'b0;
                mon_pos = 0;
            end else begin
                case (mon_pos)
                    1: exp_w = {4'b0000, cur.p[31:0]};
                    2: exp_w = {4'b0000, cur.c, 16'h0000};
                    default: exp_w = {IDLE_K, IDLE_W};
                endcase
                check($sformatf("w%0d", mon_pos), {TX_ISK, TX_DATA}, exp_w);
                mon_pos = (mon_pos == 3) ? 0 : mon_pos + 1;
            end
        end
    end

`ifdef TRG_PRBS_EN
    bit prbs_hist[$];

    function automatic logic [47:0] prbs_next48();
        logic [47:0] p;
        bit nb;
        p = '0;
        for (int i = 0; i < 48; i++) begin
            nb = prbs_hist[prbs_hist.size()-7] ^ prbs_hist[prbs_hist.size()-6];
            prbs_hist.push_back(nb);
            void'(prbs_hist.pop_front());
            p = {p[46:0], nb};
        end
        return p;
    endfunction
`endif

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        bit w;
        int stall_idx;
        int t;
        int ndrop;
        RST_N = 1'b0;
        TXRESETDONE = 1'b0;
        COMP_VLD = 1'b0;
        COMP_DATA = '0;
        PRBS_SEL = 1'b0;
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        check("rst_tx_data", 64'(TX_DATA), 64'(IDLE_W));
        check("rst_tx_isk", 64'(TX_ISK), 64'(IDLE_K));
        check("rst_comp_rdy", 64'(COMP_RDY), 64'd0);
        check("rst_frame_seq", 64'(FRAME_SEQ), 64'd0);
        check("rst_link_up", 64'(LINK_UP), 64'd0);

        RST_N = 1'b1;
        TXRESETDONE = 1'b1;
        mon_en = 1'b1;
        repeat (15) @(negedge CLK);
        check("link_up_15", 64'(LINK_UP), 64'd0);
        check("rdy_15", 64'(COMP_RDY), 64'd0);
        @(negedge CLK);
        check("link_up_16", 64'(LINK_UP), 64'd1);
        check("rdy_16", 64'(COMP_RDY), 64'd1);
        repeat (2) @(negedge CLK);

        send(48'h123456789ABC, w);
        @(negedge CLK);
        check("lat_n1_idle", 64'(TX_DATA), 64'(IDLE_W));
        @(negedge CLK);
        check("lat_w0", {TX_ISK, TX_DATA}, {4'b0001, 32'h123400BC});
        @(negedge CLK);
        check("lat_w1", {TX_ISK, TX_DATA}, {4'b0000, 32'h56789ABC});
        drain();

        stall_idx = -1;
        for (int i = 0; i < 8; i++) begin
            send({16'hA000 + 16'(i), 32'hC0DE0000 + 32'(i * 7)}, w);
            if (w && stall_idx < 0)
                stall_idx = i;
        end
        check("first_stall", 64'(stall_idx), 64'd5);
        drain();
        check("seq_after_burst", 64'(FRAME_SEQ), 64'd8);

        for (int i = 0; i < 257; i++)
            send({16'(i), 32'(i) * 32'h9E3779B9}, w);
        drain();
        check("seq_after_wrap", 64'(FRAME_SEQ), 64'd9);

        send(48'hDEAD_BEEF_0001, w);
        send(48'hDEAD_BEEF_0002, w);
        repeat (2) @(negedge CLK);
        expect_abort = 1'b1;
        TXRESETDONE = 1'b0;
        @(negedge CLK);
        #1;
        check("drop_abort", 64'(abort_seen), 64'd1);
        check("drop_tx_idle", {TX_ISK, TX_DATA}, {IDLE_K, IDLE_W});
        check("drop_rdy", 64'(COMP_RDY), 64'd0);
        check("drop_link_up", 64'(LINK_UP), 64'd0);
        check("drop_seq_kept", 64'(FRAME_SEQ), 64'd10);
        ndrop = sb.size();
        check("drop_queued", 64'(ndrop), 64'd1);
        exp_seq = exp_seq - 8'(ndrop);
        sb.delete();
        repeat (5) @(negedge CLK);
        TXRESETDONE = 1'b1;
        t = 0;
        while (!LINK_UP && t < 40) begin
            @(negedge CLK);
            t++;
        end
        check("relink_cycles", 64'(t), 64'd16);
        repeat (2) @(negedge CLK);
        send(48'h0BAD_CAFE_0003, w);
        drain();
        check("seq_after_relink", 64'(FRAME_SEQ), 64'd11);
        repeat (20) @(negedge CLK);

`ifdef TRG_PRBS_EN
        repeat (7) prbs_hist.push_back(1'b1);
        PRBS_SEL = 1'b1;
        for (int i = 0; i < 6; i++)
            expect_frame(prbs_next48());
        repeat (21) @(negedge CLK);
        PRBS_SEL = 1'b0;
        drain();
        check("seq_after_prbs", 64'(FRAME_SEQ), 64'd17);
`endif

        check("sb_empty", 64'(sb.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
